sqrt_job_driver: RTL and testbench

- Initiator for the START/DONE/AVAILABLE square-root engine handshake.
- Accepts 32-bit operands on a valid/ready stream and issues each one to the engine.
- Holds START until DONE, captures the result, releases START and waits for the engine to return idle.
- Returns {operand, root} on a valid/ready result stream. A watchdog covers an engine that never completes.

---
 rtl/sqrt_drv_pkg.sv | 18 +
 rtl/sqrt_result_check.sv | 32 +++
 rtl/sqrt_job_driver.sv | 125 ++++++++++++
 tb/tb_sqrt_job_driver.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_drv_pkg.sv
// Shared types and defaults for the square-root job driver.
package sqrt_drv_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF   = 16;

  // Result returned for an aborted job, truncated to the data width at use
  localparam logic [63:0] ERR_RESULT = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    RELEASE,
    OUT
  } state_t;

endpackage

// File: rtl/sqrt_result_check.sv
// Combinational plausibility check of an integer square root:
// bad = !(r*r <= x < (r+1)*(r+1)), products evaluated at 2*DATA_W+2 bits.
// Only present when SQRT_CHECK_EN is defined.
`ifdef SQRT_CHECK_EN
module sqrt_result_check #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] r,
  output logic              bad
);

  localparam int unsigned P_W = 2 * DATA_W + 2;

  logic [P_W-1:0] r_ext;
  logic [P_W-1:0] r_inc;
  logic [P_W-1:0] x_ext;
  logic [P_W-1:0] lo_sq;
  logic [P_W-1:0] hi_sq;

  // Bracket x between r^2 and (r+1)^2
  always_comb begin
    r_ext = P_W'(r);
    r_inc = r_ext + P_W'(1);
    x_ext = P_W'(x);
    lo_sq = r_ext * r_ext;
    hi_sq = r_inc * r_inc;
    bad   = !((lo_sq <= x_ext) && (x_ext < hi_sq));
  end

endmodule
`endif

// File: rtl/sqrt_job_driver.sv
// Initiator for a START/DONE/AVAILABLE square-root engine. Takes operands on
// a valid/ready stream, runs one engine job at a time with a DONE watchdog,
// and returns {operand, root} on a valid/ready result stream.
// Optional build macro SQRT_CHECK_EN adds the res_bad output (root checker).
module sqrt_job_driver
  import sqrt_drv_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_data,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_in,
  input  logic [DATA_W-1:0] eng_out,
  input  logic              eng_done,
  input  logic              eng_available,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] res_operand,
  output logic              res_err,
`ifdef SQRT_CHECK_EN
  output logic              res_bad,
`endif
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  jobs_done
);

  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [WD_W-1:0] watchdog;

  // Accept only when idle and the engine is ready for a fresh START
  assign op_ready = (state == IDLE) && eng_available && !eng_done;
  assign busy     = (state != IDLE);

`ifdef SQRT_CHECK_EN
  logic bad_c;

  sqrt_result_check #(
    .DATA_W (DATA_W)
  ) u_check (
    .x   (res_operand),
    .r   (res_data),
    .bad (bad_c)
  );
`endif

  // Job sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state       <= IDLE;
      watchdog    <= '0;
      eng_start   <= 1'b0;
      eng_in      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_operand <= '0;
      res_err     <= 1'b0;
      timeout_err <= 1'b0;
      jobs_done   <= '0;
`ifdef SQRT_CHECK_EN
      res_bad     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            eng_in      <= op_data;
            res_operand <= op_data;
            eng_start   <= 1'b1;
            watchdog    <= '0;
            state       <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // DONE takes priority over a timeout landing on the same cycle
          if (eng_done) begin
            res_data  <= eng_out;
            res_err   <= 1'b0;
            eng_start <= 1'b0;
            state     <= RELEASE;
          end else if (watchdog == WD_LAST) begin
            res_data    <= DATA_W'(ERR_RESULT);
            res_err     <= 1'b1;
            timeout_err <= 1'b1;
            eng_start   <= 1'b0;
            state       <= RELEASE;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        RELEASE: begin
          if (!eng_done && eng_available) begin
            res_valid <= 1'b1;
`ifdef SQRT_CHECK_EN
            res_bad   <= !res_err && bad_c;
`endif
            state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef SQRT_CHECK_EN
            res_bad   <= 1'b0;
`endif
            jobs_done <= jobs_done + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_job_driver.sv
// Self-checking bench for sqrt_job_driver with a behavioural engine model.
module tb_sqrt_job_driver;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data;
  logic        eng_start;
  logic [31:0] eng_in;
  logic [31:0] eng_out;
  logic        eng_done;
  logic        eng_available;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [31:0] res_operand;
  logic        res_err;
  logic        busy;
  logic        timeout_err;
  logic [15:0] jobs_done;
`ifdef SQRT_CHECK_EN
  logic        res_bad;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] root;
    logic        err;
    logic        bd;
  } exp_t;
  exp_t sb[$];

  logic stub_never = 1'b0;
  logic stub_wrong = 1'b0;

  always #5 clk = ~clk;

  sqrt_job_driver dut (
    .clk           (clk),
    .rstn          (rstn),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_data       (op_data),
    .eng_start     (eng_start),
    .eng_in        (eng_in),
    .eng_out       (eng_out),
    .eng_done      (eng_done),
    .eng_available (eng_available),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_operand   (res_operand),
    .res_err       (res_err),
`ifdef SQRT_CHECK_EN
    .res_bad       (res_bad),
`endif
    .busy          (busy),
    .timeout_err   (timeout_err),
    .jobs_done     (jobs_done)
  );

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  // Engine model: samples START while available, answers after LAT cycles,
  // holds DONE until START drops, then returns to available next cycle.
  logic [31:0] eng_x;
  int          eng_cnt;
  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      eng_available <= 1'b1;
      eng_done      <= 1'b0;
      eng_out       <= '0;
      eng_x         <= '0;
      eng_cnt       <= 0;
    end else if (eng_available && eng_start) begin
      eng_available <= 1'b0;
      eng_x         <= eng_in;
      eng_cnt       <= LAT;
    end else if (!eng_available && !eng_start) begin
      eng_available <= 1'b1;
      eng_done      <= 1'b0;
      eng_cnt       <= 0;
    end else if (!eng_available && !eng_done && eng_cnt > 0) begin
      if (eng_cnt == 1) begin
        if (!stub_never) begin
          eng_done <= 1'b1;
          eng_out  <= stub_wrong ? 32'd13 : isqrt(eng_x);
        end
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // Scoreboard: compare each handed-off result with the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rstn && res_valid === 1'b1 && res_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got data=%0d operand=%0d, no result expected", res_data, res_operand);
      end else begin
        e = sb.pop_front();
        if (res_data !== e.root || res_operand !== e.x || res_err !== e.err) begin
          bad++;
          $display("FAIL sb_result: got data=%0h operand=%0d err=%0b, want data=%0h operand=%0d err=%0b",
                   res_data, res_operand, res_err, e.root, e.x, e.err);
        end
`ifdef SQRT_CHECK_EN
        total++;
        if (res_bad !== e.bd) begin
          bad++;
          $display("FAIL sb_res_bad: got %0b want %0b", res_bad, e.bd);
        end
`endif
      end
    end
  end

  task automatic do_reset();
    op_valid  = 1'b0;
    op_data   = '0;
    res_ready = 1'b0;
    rstn      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    sb.delete();
  endtask

  task automatic send_op(input logic [31:0] x, input logic [31:0] root,
                         input logic err, input logic bd, input logic hold);
    int ok;
    exp_t e;
    ok       = 0;
    op_data  = x;
    op_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (op_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      total++;
      bad++;
      $display("FAIL send_op_timeout: operand %0d never accepted", x);
    end else begin
      e.x = x; e.root = root; e.err = err; e.bd = bd;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 if (!hold) op_valid = 1'b0;
  endtask

  task automatic wait_handoff(input string nm);
    int ok;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      total++;
      bad++;
      $display("FAIL %s_handoff_timeout: res_valid=%0b res_ready=%0b", nm, res_valid, res_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op_valid  = 1'b0;
    op_data   = '0;
    res_ready = 1'b0;
    rstn      = 1'b1;
    #2;
    total++;
    if ({eng_start, res_valid, res_err, timeout_err, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %05b want 00000", {eng_start, res_valid, res_err, timeout_err, busy});
    end
    total++;
    if (eng_in !== 32'd0 || res_data !== 32'd0 || res_operand !== 32'd0 || jobs_done !== 16'd0) begin
      bad++;
      $display("FAIL reset_data: eng_in=%0d res_data=%0d res_operand=%0d jobs_done=%0d want all 0",
               eng_in, res_data, res_operand, jobs_done);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
  endtask

  task automatic test_single();
    int seen_drop;
    do_reset();
    res_ready = 1'b1;
    send_op(32'd144, 32'd12, 1'b0, 1'b0, 1'b0);
    total++;
    if (eng_start !== 1'b1 || eng_in !== 32'd144 || busy !== 1'b1 || op_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_issue: start=%0b eng_in=%0d busy=%0b op_ready=%0b want 1 144 1 0",
               eng_start, eng_in, busy, op_ready);
    end
    seen_drop = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (eng_done === 1'b1) break;
      if (eng_start !== 1'b1) seen_drop = 1;
    end
    total++;
    if (seen_drop != 0 || eng_done !== 1'b1) begin
      bad++;
      $display("FAIL single_start_hold: early_drop=%0d done=%0b want 0 1", seen_drop, eng_done);
    end
    @(posedge clk);
    #1;
    total++;
    if (eng_start !== 1'b0) begin
      bad++;
      $display("FAIL single_start_release: got %0b want 0", eng_start);
    end
    wait_handoff("single");
    total++;
    if (jobs_done !== 16'd1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_count: jobs_done=%0d res_valid=%0b want 1 0", jobs_done, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [3];
    logic [31:0] roots [3];
    ops[0] = 32'd1000000; roots[0] = 32'd1000;
    ops[1] = 32'd65536;   roots[1] = 32'd256;
    ops[2] = 32'd2;       roots[2] = 32'd1;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_op(ops[i], roots[i], 1'b0, 1'b0, i < 2);
      total++;
      if (jobs_done !== 16'(i)) begin
        bad++;
        $display("FAIL b2b_no_overlap_%0d: jobs_done=%0d at accept, want %0d", i, jobs_done, i);
      end
    end
    wait_handoff("b2b");
    total++;
    if (jobs_done !== 16'd3 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: jobs_done=%0d pending=%0d want 3 0", jobs_done, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int ok;
    int errs;
    do_reset();
    send_op(32'd81, 32'd9, 1'b0, 1'b0, 1'b0);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (ok == 0) begin
      bad++;
      $display("FAIL bp_valid_timeout: res_valid=%0b want 1", res_valid);
    end
    errs = 0;
    for (int n = 0; n < 20; n++) begin
      if (res_valid !== 1'b1 || res_data !== 32'd9 || res_operand !== 32'd81 || op_ready !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bp_hold: %0d unstable cycles, last valid=%0b data=%0d op_ready=%0b want 1 9 0",
               errs, res_valid, res_data, op_ready);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_handoff("bp");
    total++;
    if (res_valid !== 1'b0 || jobs_done !== 16'd1) begin
      bad++;
      $display("FAIL bp_handoff: res_valid=%0b jobs_done=%0d want 0 1", res_valid, jobs_done);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    res_ready  = 1'b1;
    stub_never = 1'b1;
    send_op(32'h1234, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (k == 63) begin
        total++;
        if (eng_start !== 1'b1 || timeout_err !== 1'b0) begin
          bad++;
          $display("FAIL to_early: cycle 63 start=%0b timeout_err=%0b want 1 0", eng_start, timeout_err);
        end
      end
      if (k == 64) begin
        total++;
        if (eng_start !== 1'b0 || timeout_err !== 1'b1 || res_err !== 1'b1) begin
          bad++;
          $display("FAIL to_abort: cycle 64 start=%0b timeout_err=%0b res_err=%0b want 0 1 1",
                   eng_start, timeout_err, res_err);
        end
      end
    end
    stub_never = 1'b0;
    wait_handoff("to");
    send_op(32'd49, 32'd7, 1'b0, 1'b0, 1'b0);
    wait_handoff("to_next");
    total++;
    if (timeout_err !== 1'b1 || jobs_done !== 16'd2) begin
      bad++;
      $display("FAIL to_sticky: timeout_err=%0b jobs_done=%0d want 1 2", timeout_err, jobs_done);
    end
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    res_ready = 1'b1;
    send_op(32'd400, 32'd20, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (eng_start !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre: start=%0b busy=%0b want 1 1", eng_start, busy);
    end
    rstn = 1'b1;
    #1;
    total++;
    if (eng_start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_async: start=%0b res_valid=%0b busy=%0b want 0 0 0", eng_start, res_valid, busy);
    end
    sb.delete();
    @(posedge clk);
    #1 rstn = 1'b0;
    send_op(32'd400, 32'd20, 1'b0, 1'b0, 1'b0);
    wait_handoff("rst_mid");
    total++;
    if (jobs_done !== 16'd1) begin
      bad++;
      $display("FAIL rst_mid_count: jobs_done=%0d want 1", jobs_done);
    end
  endtask

`ifdef SQRT_CHECK_EN
  task automatic test_check();
    do_reset();
    res_ready  = 1'b1;
    stub_wrong = 1'b1;
    send_op(32'd144, 32'd13, 1'b0, 1'b1, 1'b0);
    wait_handoff("chk_wrong");
    stub_wrong = 1'b0;
    total++;
    if (res_bad !== 1'b0) begin
      bad++;
      $display("FAIL chk_clear: res_bad=%0b after handoff want 0", res_bad);
    end
    send_op(32'd144, 32'd12, 1'b0, 1'b0, 1'b0);
    wait_handoff("chk_good");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_job();
`ifdef SQRT_CHECK_EN
    test_check();
`endif
    repeat (4) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d results never produced, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
